slave_rtl_mem: RTL and testbench
================================

SLAVE_RTL_MEM -- requirements
Module: slave_rtl_mem

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width (8, 16 or 32).
REQ-003 Parameter NO_OF_SLAVES, default 1, width of pselx.
REQ-004 Parameter SLAVE_ID, default 0, pselx bit that selects this slave.
REQ-005 Parameter MEM_DEPTH, default 16, word count (power of two).
REQ-006 Parameter WAIT_STATES, default 2, number of pready-low ACCESS cycles (0..15).
REQ-007 Port pclk, input, 1: sole clock, rising edge.
REQ-008 Port preset, input, 1: asynchronous, active-high reset.
REQ-009 Port pselx, input, NO_OF_SLAVES: slave selects.
REQ-010 Port penable, input, 1: ACCESS phase marker.
REQ-011 Port paddr, input, ADDRESS_WIDTH: byte address.
REQ-012 Port pwrite, input, 1: 1 = write, 0 = read.
REQ-013 Port pstrb, input, DATA_WIDTH/8: write byte strobes.
REQ-014 Port pwdata, input, DATA_WIDTH: write data.
REQ-015 Port pprot, input, 3: protection type; bit0 = privileged.
REQ-016 Port pready, output, 1: transfer completion.
REQ-017 Port prdata, output, DATA_WIDTH: read data.
REQ-018 Port pslverr, output, 1: transfer error.

Function
REQ-019 sel = pselx[SLAVE_ID]; SETUP = sel && !penable; complete = sel && penable && pready.
REQ-020 FSM states: IDLE, WAIT, READY; all outputs are registered.
REQ-021 IDLE: on SETUP, latch paddr, pwrite, pstrb, pwdata and pprot, and load wcnt = WAIT_STATES; go to READY if WAIT_STATES==0, else go to WAIT.
REQ-022 WAIT: decrement wcnt each cycle while sel && penable; on wcnt reaching 1, go to READY; pready stays 0 in WAIT.
REQ-023 READY: pready=1 for exactly one cycle; a write commits at this edge; then return to IDLE, which accepts a back-to-back SETUP on the next cycle.
REQ-024 Transfer latency: first ACCESS cycle to pready = WAIT_STATES cycles; total transfer length = 2 + WAIT_STATES cycles.
REQ-025 Error conditions:
- paddr not aligned to DATA_WIDTH/8 bytes;
- paddr >= MEM_DEPTH*(DATA_WIDTH/8).
On error: pslverr=1 with pready, no memory update, prdata=0.
REQ-026 Write: update only the bytes whose pstrb bit is 1; pstrb=0 is a legal no-op.
REQ-027 Read: prdata = mem[index] while pready=1, else 0; pstrb is ignored on reads.
REQ-028 pslverr=0 whenever pready=0.
REQ-029 If sel drops before completion, go to IDLE, commit nothing, and keep pready=0.
REQ-030 Memory index = paddr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]; upper address bits are checked only by REQ-025.

Reset
REQ-031 While preset=1, asynchronously force: FSM to IDLE, wcnt=0, pready=0, pslverr=0, prdata=0, all memory words to 0.
REQ-032 Reset asserted mid-transfer aborts it with no write committed; the first SETUP after reset release is serviced normally.

Configuration
REQ-033 Macro SLAVE_RTL_PPROT_CHECK_EN.
- Defined: an access to the upper half of memory (index >= MEM_DEPTH/2) with pprot[0]=0 completes with pslverr=1, no write, prdata=0.
- Undefined: pprot is latched but ignored.

Structure
REQ-034 Package Master_RTL_global_pkg (the shared package) holds ADDRESS_WIDTH, DATA_WIDTH and NO_OF_SLAVES defaults plus the slave_fsm_e enum (IDLE, WAIT, READY).
REQ-035 Sub-module slave_rtl_mem_array: byte-strobed register array with asynchronous clear, a synchronous write port and a combinational read port.

Verification
REQ-036 Write 0xA5A5_1234 to 0x08 with pstrb=4'hF, then read 0x08 -> pready high on the third ACCESS cycle (WAIT_STATES=2), prdata=0xA5A5_1234, pslverr=0.
REQ-037 Write 0xFFFF_FFFF to 0x04 with pstrb=4'b0101 over a zero word, then read -> prdata=0x00FF_00FF.
REQ-038 Read 0x40 (out of range) and write 0x02 (misaligned) -> pslverr=1 with pready, prdata=0, memory unchanged.
REQ-039 Back-to-back writes to 0x00 and 0x04 with no idle cycle -> both complete, each lasting 4 cycles, and both words are correct.
REQ-040 Assert preset during WAIT of a write to 0x0C, then read 0x0C -> pready=0 immediately, prdata=0x0, write dropped.
REQ-041 With SLAVE_RTL_PPROT_CHECK_EN defined, write 0x20 with pprot=3'b000 -> pslverr=1; repeat with pprot=3'b001 -> pslverr=0 and data stored.

Source files
------------

// File: rtl/Master_RTL_global_pkg.sv
// Shared APB definitions: bus-width defaults and the slave FSM state encoding.
package Master_RTL_global_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_NO_OF_SLAVES  = 1;

  // Slave transfer FSM: IDLE waits for SETUP, WAIT holds pready low,
  // READY drives the single completion cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } slave_fsm_e;

endpackage

// File: rtl/slave_rtl_mem_array.sv
// Byte-strobed register array: async clear, synchronous write, combinational read.
module slave_rtl_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH/8-1:0]      wstrb_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]        rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Storage: every word cleared on reset, strobed bytes written on we_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/slave_rtl_mem.sv
// APB slave with a word-addressed memory and a fixed number of wait states.
// Optional feature: define SLAVE_RTL_PPROT_CHECK_EN to reject unprivileged
// accesses (pprot[0]=0) to the upper half of the memory with pslverr.
// Handshake: a transfer is SETUP (sel && !penable) followed by ACCESS cycles
// (sel && penable); it completes in the single cycle where pready=1, and
// pslverr/prdata are meaningful only in that cycle (both 0 otherwise).
module slave_rtl_mem
  import Master_RTL_global_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NO_OF_SLAVES  = DEF_NO_OF_SLAVES,
  parameter int SLAVE_ID      = 0,
  parameter int MEM_DEPTH     = 16,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [NO_OF_SLAVES-1:0]  pselx,
  input  logic                     penable,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic                     pwrite,
  input  logic [DATA_WIDTH/8-1:0]  pstrb,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  input  logic [2:0]               pprot,
  output logic                     pready,
  output logic [DATA_WIDTH-1:0]    prdata,
  output logic                     pslverr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(NB);
  localparam logic [3:0]               WS_LOAD    = 4'(WAIT_STATES);
  localparam logic [ADDRESS_WIDTH:0]   ADDR_LIMIT = (ADDRESS_WIDTH+1)'(MEM_DEPTH * NB);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(NB - 1);

  slave_fsm_e state_q, state_d;
  logic [3:0]               wcnt_q, wcnt_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [NB-1:0]            pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic [2:0]               pprot_q, pprot_d;
  logic                     pready_q, pready_d;
  logic                     pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]    prdata_q, prdata_d;

  logic                  sel, setup, access, err_d, mem_we;
  logic [IW-1:0]         idx_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_ok;

  assign sel    = pselx[SLAVE_ID];
  assign setup  = sel && !penable;
  assign access = sel && penable;

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

  // Capture the request on SETUP in IDLE; hold it for the rest of the transfer.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    pwdata_d = pwdata_q;
    pprot_d  = pprot_q;
    if (state_q == IDLE && setup) begin
      paddr_d  = paddr;
      pwrite_d = pwrite;
      pstrb_d  = pstrb;
      pwdata_d = pwdata;
      pprot_d  = pprot;
    end
  end

  assign idx_d = paddr_d[BW +: IW];

  // Error decode on the request that will be answered when READY is entered.
  always_comb begin
    err_d = ((paddr_d & ALIGN_MASK) != '0) || ({1'b0, paddr_d} >= ADDR_LIMIT);
`ifdef SLAVE_RTL_PPROT_CHECK_EN
    if (idx_d[IW-1] && !pprot_d[0]) err_d = 1'b1;
`else
    err_d = err_d;
`endif
  end

  // Next state and registered outputs; outputs are non-zero only in READY.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          wcnt_d = WS_LOAD;
          if (WAIT_STATES == 0) state_d = READY;
          else                  state_d = WAIT;
        end
      end
      WAIT: begin
        if (!sel) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (penable) begin
          if (wcnt_q <= 4'd1) begin
            state_d = READY;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
      end
      READY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
    if (state_d == READY) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      prdata_d  = (err_d || pwrite_d) ? '0 : mem_rdata;
    end
  end

  // Writes land at the end of the completing READY cycle, never on error.
  assign mem_we = (state_q == READY) && access && pwrite_q && !pslverr_q;

  // FSM, request latches and output registers.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= '0;
      pwdata_q  <= '0;
      pprot_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pstrb_q   <= pstrb_d;
      pwdata_q  <= pwdata_d;
      pprot_q   <= pprot_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  slave_rtl_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk_i  (pclk),
    .rst_i  (preset),
    .we_i   (mem_we),
    .waddr_i(paddr_q[BW +: IW]),
    .wstrb_i(pstrb_q),
    .wdata_i(pwdata_q),
    .raddr_i(idx_d),
    .rdata_o(mem_rdata)
  );

  // Unselected slave bits and the pprot bits that carry no function here.
  assign unused_ok = ^{pselx, pprot_q};

endmodule

// File: tb/tb_slave_rtl_mem.sv
// Self-checking bench for slave_rtl_mem (default parameters).
module tb_slave_rtl_mem;

  localparam int WS    = 2;
  localparam int DEPTH = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic [0:0]  pselx;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [2:0]  pprot;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];

  slave_rtl_mem dut (
    .pclk   (pclk),
    .preset (preset),
    .pselx  (pselx),
    .penable(penable),
    .paddr  (paddr),
    .pwrite (pwrite),
    .pstrb  (pstrb),
    .pwdata (pwdata),
    .pprot  (pprot),
    .pready (pready),
    .prdata (prdata),
    .pslverr(pslverr)
  );

  // Clock
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules: word aligned, inside 16 words, optional privilege on upper half.
  function automatic logic model_err(input logic [31:0] addr, input logic [2:0] prot);
    logic e;
    e = (addr % 4 != 0) || (addr >= DEPTH * 4);
`ifdef SLAVE_RTL_PPROT_CHECK_EN
    if (!e && (addr / 4) >= DEPTH / 2 && !prot[0]) e = 1'b1;
`else
    if (prot == 3'b111) e = e;
`endif
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic bus_idle();
    pselx = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pstrb = '0; pwdata = '0; pprot = '0;
  endtask

  // One full APB transfer; starts just after a rising edge, ends likewise.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic [2:0] prot);
    logic        e;
    int          n;
    bit          done;
    e = model_err(addr, prot);
    exp_q.push_back((wr || e) ? 32'h0 : ref_mem[(addr / 4) % DEPTH]);
    pselx = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
    pstrb = strb; pwdata = wdata; pprot = prot;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 2;
    done = 0;
    while (!done && n < 2 + WS + 10) begin
      @(negedge pclk);
      if (pready) begin
        done = 1;
      end else begin
        check_eq("wait_pslverr", {31'd0, pslverr}, 32'd0);
        check_eq("wait_prdata", prdata, 32'd0);
        @(posedge pclk); #1;
        n++;
      end
    end
    check_eq("xfer_len", n, 2 + WS);
    check_eq("pready", {31'd0, pready}, 32'd1);
    check_eq("pslverr", {31'd0, pslverr}, {31'd0, e});
    check_eq("prdata", prdata, exp_q.pop_front());
    if (wr && !e) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr / 4][b*8 +: 8] = wdata[b*8 +: 8];
    end
    @(posedge pclk); #1;
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] addr);
    apb_xfer(addr, 1'b0, 4'h0, 32'h0, 3'b001);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  initial begin
    bus_idle();
    model_clear();
    preset = 1'b1;
    #3;
    check_eq("rst_pready", {31'd0, pready}, 32'd0);
    check_eq("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check_eq("rst_prdata", prdata, 32'd0);
    @(negedge pclk); @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Full write then read back.
    apb_xfer(32'h08, 1'b1, 4'hF, 32'hA5A5_1234, 3'b000);
    rd(32'h08);
    check_eq("d_word08", ref_mem[2], 32'hA5A5_1234);

    // Partial strobes over a zero word.
    apb_xfer(32'h04, 1'b1, 4'b0101, 32'hFFFF_FFFF, 3'b000);
    rd(32'h04);

    // Out of range read, misaligned write, then confirm word 0 untouched.
    rd(32'h40);
    apb_xfer(32'h02, 1'b1, 4'hF, 32'hDEAD_BEEF, 3'b001);
    rd(32'h00);

    // Back-to-back writes, no idle cycle between them.
    apb_xfer(32'h00, 1'b1, 4'hF, 32'h1111_0000, 3'b000);
    apb_xfer(32'h04, 1'b1, 4'hF, 32'h2222_0004, 3'b000);
    rd(32'h00);
    rd(32'h04);

    // pstrb=0 write is a no-op.
    apb_xfer(32'h08, 1'b1, 4'h0, 32'h0BAD_0BAD, 3'b000);
    rd(32'h08);

    // Privilege handling on the upper half.
    apb_xfer(32'h20, 1'b1, 4'hF, 32'h5A5A_0020, 3'b000);
    apb_xfer(32'h20, 1'b1, 4'hF, 32'h6B6B_0020, 3'b001);
    rd(32'h20);

    // Select dropped during WAIT: nothing committed, pready stays low.
    pselx = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1;
    pstrb = 4'hF; pwdata = 32'hCAFE_0010;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check_eq("abort_pready", {31'd0, pready}, 32'd0);
    end
    @(posedge pclk); #1;
    rd(32'h10);

    // Reset during WAIT of a write to 0x0C.
    apb_xfer(32'h0C, 1'b1, 4'hF, 32'h7777_000C, 3'b000);
    pselx = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1;
    pstrb = 4'hF; pwdata = 32'h9999_000C;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check_eq("rstw_pready_pre", {31'd0, pready}, 32'd0);
    preset = 1'b1;
    #1;
    check_eq("rstw_pready", {31'd0, pready}, 32'd0);
    check_eq("rstw_prdata", prdata, 32'd0);
    model_clear();
    @(posedge pclk); #1;
    bus_idle();
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk); #1;
    rd(32'h0C);
    check_eq("rstw_model0C", ref_mem[3], 32'h0);

    // Randomized traffic against the model.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      apb_xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               $urandom, 3'($urandom_range(0, 7)));
      idle_cycles($urandom_range(0, 2));
    end

    // Final sweep of every word.
    for (int i = 0; i < DEPTH; i++) rd(32'(i * 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
